// File: rtl/dmem_arbiter_pkg.sv
// Shared types and sizes for the DATA_MEMORY arbiter slice.
//   ADDRESS_SIZE / N : memory address and data widths
//   dmem_state_t     : sequencer states
//   dmem_req_t       : one request payload (write flag, address, write data)
package dmem_pkg;

  localparam int unsigned ADDRESS_SIZE = 10;
  localparam int unsigned N            = 64;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} dmem_state_t;

  typedef struct packed {
    logic                    we;
    logic [ADDRESS_SIZE-1:0] addr;
    logic [N-1:0]            wdata;
  } dmem_req_t;

endpackage

// File: rtl/dmem_arbiter_if.sv
// Bundle of the requester handshake and the DATA_MEMORY bus.
//   slave  : the arbiter (takes requests, drives the memory strobes/addresses)
//   master : the environment (requesters plus the memory returning data_out)
interface dmem_arbiter_if;
  import dmem_pkg::*;

  logic [1:0]                        req_valid;
  logic [1:0]                        req_ready;
  logic [1:0]                        req_we;
  logic [1:0][ADDRESS_SIZE-1:0]      req_addr;
  logic [1:0][N-1:0]                 req_wdata;
  logic [1:0]                        rsp_valid;
  logic [N-1:0]                      rsp_rdata;
  logic                              mem_read;
  logic                              mem_write;
  logic [ADDRESS_SIZE-1:0]           rd_addr;
  logic [ADDRESS_SIZE-1:0]           wr_addr;
  logic [N-1:0]                      data_in;
  logic [N-1:0]                      data_out;

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, data_out,
    output req_ready, rsp_valid, rsp_rdata, mem_read, mem_write, rd_addr, wr_addr, data_in
  );

  modport master (
    output req_valid, req_we, req_addr, req_wdata, data_out,
    input  req_ready, rsp_valid, rsp_rdata, mem_read, mem_write, rd_addr, wr_addr, data_in
  );

endinterface

// File: rtl/dmem_arbiter_rr.sv
// Two-way round-robin arbiter.
//   clk_i, rst_i : clock, asynchronous active-high reset
//   req_i        : per-requester request
//   accept_i     : a grant was taken this cycle; hand priority to the other side
//   grant_o      : one-hot (or zero) combinational grant
module rr_arbiter2 (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [1:0] req_i,
  input  logic       accept_i,
  output logic [1:0] grant_o
);

  logic rr_ptr_q, rr_ptr_d;

  always_comb begin
    grant_o = '0;
    case (req_i)
      2'b01:   grant_o = 2'b01;
      2'b10:   grant_o = 2'b10;
      2'b11:   grant_o = rr_ptr_q ? 2'b10 : 2'b01;
      default: grant_o = '0;
    endcase
  end

  // Kept apart from the grant logic: accept_i is itself derived from grant_o.
  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (accept_i) rr_ptr_d = ~grant_o[1];
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) rr_ptr_q <= 1'b0;
    else       rr_ptr_q <= rr_ptr_d;
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Shares the single-ported DATA_MEMORY between the core (requester 0) and the
// debug/DMA loader (requester 1), one transaction at a time.
//   clk, rst : clock, asynchronous active-high reset
//   bus      : requester handshake (req_*/rsp_*) and memory bus (mem_*, addresses, data)
//   RD_LAT   : cycles from the mem_read cycle until data_out is valid (1..7)
module dmem_arbiter
  import dmem_pkg::*;
#(
  parameter int unsigned RD_LAT = 1
) (
  input logic           clk,
  input logic           rst,
  dmem_arbiter_if.slave bus
);

  localparam logic [2:0] WAIT_LAST = 3'(RD_LAT - 1);

  dmem_state_t             state_q, state_d;
  logic                    owner_q, owner_d;
  logic                    we_q, we_d;
  logic [2:0]              cnt_q, cnt_d;
  logic [ADDRESS_SIZE-1:0] rd_addr_q, rd_addr_d;
  logic [ADDRESS_SIZE-1:0] wr_addr_q, wr_addr_d;
  logic [N-1:0]            data_in_q, data_in_d;
  logic [N-1:0]            rdata_q, rdata_d;

  logic [1:0] grant;
  logic       accept;
  logic       win_id;
  dmem_req_t  win_req;

  rr_arbiter2 u_rr (
    .clk_i    (clk),
    .rst_i    (rst),
    .req_i    (bus.req_valid),
    .accept_i (accept),
    .grant_o  (grant)
  );

  // rst gates the handshake so req_ready is 0 while reset is held.
  assign accept  = (state_q == IDLE) && !rst && (|(bus.req_valid & grant));
  assign win_id  = grant[1];
  assign win_req = '{we:    bus.req_we[win_id],
                     addr:  bus.req_addr[win_id],
                     wdata: bus.req_wdata[win_id]};

  // Captured payload lands directly in the address/data output registers, so
  // they keep their last driven value between transactions.
  always_comb begin
    state_d   = state_q;
    owner_d   = owner_q;
    we_d      = we_q;
    cnt_d     = cnt_q;
    rd_addr_d = rd_addr_q;
    wr_addr_d = wr_addr_q;
    data_in_d = data_in_q;
    rdata_d   = rdata_q;

    bus.req_ready = '0;
    bus.rsp_valid = '0;
    bus.mem_read  = 1'b0;
    bus.mem_write = 1'b0;

    case (state_q)
      IDLE: begin
        if (!rst) bus.req_ready = grant;
        if (accept) begin
          owner_d = win_id;
          we_d    = win_req.we;
          if (win_req.we) begin
            wr_addr_d = win_req.addr;
            data_in_d = win_req.wdata;
          end else begin
            rd_addr_d = win_req.addr;
          end
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        if (we_q) begin
          bus.mem_write = 1'b1;
          rdata_d       = '0;
          state_d       = RESP;
        end else begin
          bus.mem_read = 1'b1;
          cnt_d        = '0;
          state_d      = WAIT;
        end
      end
      WAIT: begin
        if (cnt_q == WAIT_LAST) begin
          rdata_d = bus.data_out;
          cnt_d   = '0;
          state_d = RESP;
        end else begin
          cnt_d = cnt_q + 3'd1;
        end
      end
      RESP: begin
        bus.rsp_valid[owner_q] = 1'b1;
        state_d                = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      owner_q   <= 1'b0;
      we_q      <= 1'b0;
      cnt_q     <= '0;
      rd_addr_q <= '0;
      wr_addr_q <= '0;
      data_in_q <= '0;
      rdata_q   <= '0;
    end else begin
      state_q   <= state_d;
      owner_q   <= owner_d;
      we_q      <= we_d;
      cnt_q     <= cnt_d;
      rd_addr_q <= rd_addr_d;
      wr_addr_q <= wr_addr_d;
      data_in_q <= data_in_d;
      rdata_q   <= rdata_d;
    end
  end

  assign bus.rd_addr   = rd_addr_q;
  assign bus.wr_addr   = wr_addr_q;
  assign bus.data_in   = data_in_q;
  assign bus.rsp_rdata = rdata_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: two instances (RD_LAT=1 and RD_LAT=3), each with a
// behavioural memory, a per-cycle monitor and a response scoreboard.
module tb_dmem_arbiter;

  typedef struct {
    int          due;
    logic [1:0]  vec;
    logic [63:0] rdata;
  } exp_t;

  logic clk;
  logic rst;
  int   cyc;
  int   checks;
  int   errors;

  logic [1:0]       t_valid [2];
  logic [1:0]       t_we    [2];
  logic [1:0][9:0]  t_addr  [2];
  logic [1:0][63:0] t_wdata [2];

  logic [1:0]  o_ready [2];
  logic [1:0]  o_rspv  [2];
  logic [63:0] o_rdata [2];
  logic        o_mr    [2];
  logic        o_mw    [2];
  logic [9:0]  o_rda   [2];
  logic [9:0]  o_wra   [2];
  logic [63:0] o_din   [2];

  int outstanding [2];
  int acc_log0 [$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  for (genvar g = 0; g < 2; g++) begin : gen_dut
    localparam int LAT = (g == 0) ? 1 : 3;

    dmem_arbiter_if bus ();

    dmem_arbiter #(.RD_LAT(LAT)) u_dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
    );

    logic [63:0] mem    [1024];
    logic [63:0] shadow [1024];
    logic [63:0] pipe   [8];
    exp_t        sb [$];
    exp_t        e_m;
    int          busy_until;
    logic        mptr;
    logic        iss_pend, iss_we;
    logic [9:0]  iss_addr, last_rd, last_wr;
    logic [63:0] iss_data, last_din;
    logic [1:0]  exp_rdy, acc;
    int          id;

    assign bus.req_valid = t_valid[g];
    assign bus.req_we    = t_we[g];
    assign bus.req_addr  = t_addr[g];
    assign bus.req_wdata = t_wdata[g];
    assign bus.data_out  = pipe[LAT-1];

    assign o_ready[g] = bus.req_ready;
    assign o_rspv[g]  = bus.rsp_valid;
    assign o_rdata[g] = bus.rsp_rdata;
    assign o_mr[g]    = bus.mem_read;
    assign o_mw[g]    = bus.mem_write;
    assign o_rda[g]   = bus.rd_addr;
    assign o_wra[g]   = bus.wr_addr;
    assign o_din[g]   = bus.data_in;

    initial begin
      for (int i = 0; i < 1024; i++) begin
        mem[i]    = '0;
        shadow[i] = '0;
      end
      for (int k = 0; k < 8; k++) pipe[k] = 64'hDEAD_BEEF_DEAD_BEEF;
      busy_until = -1;
      mptr = 1'b0;
      iss_pend = 1'b0;
      iss_we = 1'b0;
      iss_addr = '0;
      iss_data = '0;
      last_rd = '0;
      last_wr = '0;
      last_din = '0;
    end

    // Memory: data for a read issued in cycle C is presented during C+LAT only.
    always @(posedge clk) begin
      if (bus.mem_write) mem[bus.wr_addr] <= bus.data_in;
      pipe[0] <= bus.mem_read ? mem[bus.rd_addr] : 64'hDEAD_BEEF_DEAD_BEEF;
      for (int k = 7; k > 0; k--) pipe[k] <= pipe[k-1];
    end

    always @(negedge clk) begin
      if (rst) begin
        sb.delete();
        outstanding[g] = 0;
        busy_until = -1;
        mptr = 1'b0;
        iss_pend = 1'b0;
        last_rd = '0;
        last_wr = '0;
        last_din = '0;
      end else begin
        chk("rw_exclusive", 64'(bus.mem_read & bus.mem_write), 64'd0);
        chk("rsp_onehot0", 64'($onehot0(bus.rsp_valid)), 64'd1);
        chk("ready_onehot0", 64'($onehot0(bus.req_ready)), 64'd1);

        if (iss_pend) begin
          iss_pend = 1'b0;
          if (iss_we) begin
            chk("issue_wr_strobe", 64'({bus.mem_read, bus.mem_write}), 64'd1);
            chk("issue_wr_addr", 64'(bus.wr_addr), 64'(iss_addr));
            chk("issue_data_in", bus.data_in, iss_data);
            chk("issue_rd_addr_hold", 64'(bus.rd_addr), 64'(last_rd));
            last_wr  = iss_addr;
            last_din = iss_data;
          end else begin
            chk("issue_rd_strobe", 64'({bus.mem_read, bus.mem_write}), 64'd2);
            chk("issue_rd_addr", 64'(bus.rd_addr), 64'(iss_addr));
            chk("issue_wr_addr_hold", 64'(bus.wr_addr), 64'(last_wr));
            chk("issue_data_in_hold", bus.data_in, last_din);
            last_rd = iss_addr;
          end
        end else begin
          chk("strobe_idle", 64'({bus.mem_read, bus.mem_write}), 64'd0);
          chk("rd_addr_hold", 64'(bus.rd_addr), 64'(last_rd));
          chk("wr_addr_hold", 64'(bus.wr_addr), 64'(last_wr));
          chk("data_in_hold", bus.data_in, last_din);
        end

        if (sb.size() > 0 && cyc == sb[0].due) begin
          e_m = sb.pop_front();
          chk("rsp_valid", 64'(bus.rsp_valid), 64'(e_m.vec));
          chk("rsp_rdata", bus.rsp_rdata, e_m.rdata);
          outstanding[g] = outstanding[g] - 1;
        end else begin
          chk("rsp_quiet", 64'(bus.rsp_valid), 64'd0);
        end

        exp_rdy = 2'b00;
        if (cyc > busy_until) begin
          case (bus.req_valid)
            2'b01:   exp_rdy = 2'b01;
            2'b10:   exp_rdy = 2'b10;
            2'b11:   exp_rdy = mptr ? 2'b10 : 2'b01;
            default: exp_rdy = 2'b00;
          endcase
        end
        chk("req_ready", 64'(bus.req_ready), 64'(exp_rdy));

        acc = bus.req_valid & exp_rdy;
        if (acc != 2'b00) begin
          id = acc[1] ? 1 : 0;
          e_m.vec = acc[1] ? 2'b10 : 2'b01;
          if (bus.req_we[id]) begin
            e_m.due   = cyc + 2;
            e_m.rdata = '0;
            shadow[bus.req_addr[id]] = bus.req_wdata[id];
          end else begin
            e_m.due   = cyc + 2 + LAT;
            e_m.rdata = shadow[bus.req_addr[id]];
          end
          sb.push_back(e_m);
          iss_pend = 1'b1;
          iss_we   = bus.req_we[id];
          iss_addr = bus.req_addr[id];
          iss_data = bus.req_wdata[id];
          busy_until = e_m.due;
          mptr = ~acc[1];
          outstanding[g] = outstanding[g] + 1;
          if (g == 0) acc_log0.push_back(id);
        end
      end
    end
  end

  // Drive one request and hold it until accepted; returns the accept cycle.
  task automatic issue(input int g, input int id, input logic we, input logic [9:0] addr,
                       input logic [63:0] wd, output int acc);
    acc = -1;
    t_we[g][id]    = we;
    t_addr[g][id]  = addr;
    t_wdata[g][id] = wd;
    t_valid[g][id] = 1'b1;
    for (int t = 0; t < 60; t++) begin
      #1;
      if (o_ready[g][id]) begin
        acc = cyc;
        break;
      end
      @(posedge clk);
    end
    chk("accepted", 64'(acc >= 0), 64'd1);
    @(posedge clk);
    #1;
    t_valid[g][id] = 1'b0;
  endtask

  task automatic wait_idle(input int g);
    for (int t = 0; t < 100; t++) begin
      if (outstanding[g] == 0) break;
      @(posedge clk);
    end
    chk("drained", 64'(outstanding[g]), 64'd0);
    @(posedge clk);
    #1;
  endtask

  task automatic chk_zero(input int g);
    chk("rst_req_ready", 64'(o_ready[g]), 64'd0);
    chk("rst_rsp_valid", 64'(o_rspv[g]), 64'd0);
    chk("rst_rsp_rdata", o_rdata[g], 64'd0);
    chk("rst_strobes", 64'({o_mr[g], o_mw[g]}), 64'd0);
    chk("rst_rd_addr", 64'(o_rda[g]), 64'd0);
    chk("rst_wr_addr", 64'(o_wra[g]), 64'd0);
    chk("rst_data_in", o_din[g], 64'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int a, aw, ar, base;
    logic [9:0]  sa;
    logic [63:0] sd;
    checks = 0;
    errors = 0;
    rst = 1'b1;
    for (int g = 0; g < 2; g++) begin
      t_valid[g] = '0;
      t_we[g]    = '0;
      t_addr[g]  = '0;
      t_wdata[g] = '0;
    end
    repeat (3) @(posedge clk);
    #1;
    chk_zero(0);
    chk_zero(1);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Single write from requester 0, then read back by requester 1.
    issue(0, 0, 1'b1, 10'h064, 64'h13880, a);
    wait_idle(0);
    issue(1, 0, 1'b1, 10'h064, 64'h13880, a);
    wait_idle(1);
    issue(0, 1, 1'b0, 10'h064, 64'h0, a);
    wait_idle(0);
    issue(1, 1, 1'b0, 10'h064, 64'h0, a);
    wait_idle(1);

    // Reset in the middle of a RD_LAT=3 read's WAIT phase.
    issue(1, 0, 1'b0, 10'h064, 64'h0, a);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    chk_zero(1);
    @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (8) begin
      @(negedge clk);
      chk("abort_rsp_valid", 64'(o_rspv[1]), 64'd0);
      chk("abort_strobes", 64'({o_mr[1], o_mw[1]}), 64'd0);
    end
    @(posedge clk);
    #1;
    issue(1, 1, 1'b1, 10'h0AB, 64'hA5A5_0000_5A5A_1234, a);
    wait_idle(1);
    issue(1, 0, 1'b0, 10'h0AB, 64'h0, a);
    wait_idle(1);

    // Contention: both requesters valid straight out of reset.
    rst = 1'b1;
    t_we[0]       = 2'b11;
    t_addr[0][0]  = 10'h010;
    t_addr[0][1]  = 10'h020;
    t_wdata[0][0] = 64'h1111;
    t_wdata[0][1] = 64'h2222;
    t_valid[0]    = 2'b11;
    #1;
    chk("rst_ready_contention", 64'(o_ready[0]), 64'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    base = acc_log0.size();
    for (int t = 0; t < 40; t++) begin
      if (acc_log0.size() >= base + 4) break;
      @(posedge clk);
      #1;
    end
    t_valid[0] = 2'b00;
    chk("contention_count", 64'(acc_log0.size() - base), 64'd4);
    for (int i = 0; i < 4 && base + i < acc_log0.size(); i++)
      chk("contention_order", 64'(acc_log0[base+i]), 64'(i % 2));
    wait_idle(0);
    issue(0, 1, 1'b0, 10'h020, 64'h0, a);
    wait_idle(0);

    // Streaming write/read pairs from requester 0 (RD_LAT=1).
    ar = 0;
    for (int i = 0; i < 20; i++) begin
      sa = 10'h064 + 10'($urandom_range(0, 30));
      sd = {$urandom, $urandom};
      issue(0, 0, 1'b1, sa, sd, aw);
      if (i > 0) chk("stream_read_to_write_gap", 64'(aw - ar), 64'd4);
      issue(0, 0, 1'b0, sa, 64'h0, ar);
      chk("stream_write_to_read_gap", 64'(ar - aw), 64'd3);
    end
    wait_idle(0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
Two-port arbiter and sequencer that shares the single-ported DATA_MEMORY (10-bit address, 64-bit data) between requester 0 (core load/store path) and requester 1 (debug/DMA loader).
It accepts one transaction at a time using a valid/ready request handshake and round-robin priority.
It drives mem_read/mem_write for exactly one cycle per transaction, waits the memory read latency, and returns a one-cycle response pulse to the owning requester.

Parameters:
ADDRESS_SIZE, 10, memory address width
N, 64, data width
RD_LAT, 1, cycles from the mem_read issue cycle until data_out is valid (range 1..7)

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous, active-high reset
req_valid  input  [1:0]  per-requester request valid
req_ready  output  [1:0]  per-requester accept; one-hot or zero
req_we  input  [1:0]  1 = write, 0 = read
req_addr  input  [1:0][ADDRESS_SIZE-1:0]  request address
req_wdata  input  [1:0][N-1:0]  write data
rsp_valid  output  [1:0]  one-cycle completion pulse, one-hot or zero
rsp_rdata  output  [N-1:0]  read data, qualified by rsp_valid
mem_read  output  1  to DATA_MEMORY
mem_write  output  1  to DATA_MEMORY
rd_addr  output  ADDRESS_SIZE  to DATA_MEMORY
wr_addr  output  ADDRESS_SIZE  to DATA_MEMORY
data_in  output  N  to DATA_MEMORY
data_out  input  N  from DATA_MEMORY

Behaviour:
- Reset (async, rst=1): all outputs 0; state IDLE; rr_ptr=0 (requester 0 preferred); wait counter 0. Asserting rst mid-transaction aborts it silently: no mem strobe and no rsp_valid after release.
- FSM states: IDLE -> ISSUE -> (write: RESP | read: WAIT) -> RESP -> IDLE.
- IDLE: req_ready is combinational, asserted only in IDLE, for the winner.
  - Winner is the sole requester; if both request, the requester equal to rr_ptr.
  - On accept (req_valid & req_ready), register we/addr/wdata and the owner id, set rr_ptr to the other requester, and go to ISSUE.
- ISSUE, one cycle:
  - Write: mem_write=1, wr_addr=captured addr, data_in=captured wdata.
  - Read: mem_read=1, rd_addr=captured addr.
  - mem_read and mem_write are never both 1.
- WAIT (reads only): lasts RD_LAT cycles, counted by a 3-bit counter. data_out is captured into rsp_rdata on the final WAIT edge.
- RESP, one cycle: rsp_valid[owner]=1. rsp_rdata holds the read data, or 0 for writes. rsp_rdata holds its value until the next RESP. Next state is IDLE.
- Latency from the accept cycle N:
  - Write response in cycle N+2.
  - Read response in cycle N+2+RD_LAT.
  - No new accept before the cycle after RESP.
- Address and data hold: rd_addr, wr_addr and data_in keep their last driven value between transactions. Only the strobes return to 0.
- Requester protocol: keep req_valid and the payload stable until req_ready. The arbiter samples the payload only in the accept cycle. A request dropped before accept is ignored.
- No address-range checking is needed: the 10-bit address covers all of DATA_MEMORY.

Decomposition:
- Package dmem_pkg holds:
  - ADDRESS_SIZE and N localparams
  - typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} dmem_state_t
  - packed struct dmem_req_t {we, addr, wdata}
- Sub-module rr_arbiter2: 2-way round-robin, combinational grant from req and rr_ptr, plus a registered rr_ptr update on accept.

Test Plan:
- Reset: assert rst during WAIT of a read -> all outputs 0 immediately, rsp_valid stays 0 after release, and the next request from requester 1 alone is accepted.
- Single write: requester 0 writes addr 0x064, data 0x13880, accepted in cycle N -> cycle N+1 shows mem_write=1, wr_addr=0x064, data_in=0x13880; cycle N+2 shows rsp_valid=2'b01, rsp_rdata=0.
- Write then read back: requester 1 reads 0x064 after the write above, accepted in cycle M -> mem_read=1 and rd_addr=0x064 at M+1; rsp_valid=2'b10 and rsp_rdata=0x13880 at M+3 (RD_LAT=1). Repeat with RD_LAT=3: response at M+5.
- Contention: both requesters hold valid from reset -> accept order 0,1,0,1 over 4 transactions, with req_ready never 2'b11.
- Single requester streaming: requester 0 issues 20 random writes to 0x064..0x082, each followed by a read of the same address -> every read returns its prior write data, with one accept every 3 cycles for writes and every 3+RD_LAT cycles for reads.
- Assertions run throughout all scenarios: no cycle has mem_read&mem_write; rsp_valid and req_ready are each $onehot0; exactly one strobe cycle per accept.
